code_gen: RTL and testbench

//   Issues the 4-digit combination that the joystick lock checker consumes. A

---
 rtl/code_gen.sv | 137 +++++++++++++
 tb/tb_code_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/code_gen.sv
// Combination generator for the joystick lock checker: LFSR-sourced 3-bit digits,
// no two adjacent digits equal, armed with a timeout and a saturating solve counter.
module code_gen #(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int          CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen_req,
    input  logic             pass_flag,
    output logic [2:0]       num_1,
    output logic [2:0]       num_2,
    output logic [2:0]       num_3,
    output logic [2:0]       num_4,
    output logic             code_valid,
    output logic             solved,
    output logic             timeout_pulse,
    output logic             checker_rst_n,
    output logic [CNT_W-1:0] solve_count
);

    typedef enum logic [1:0] {IDLE, GEN, ARMED, SOLVED} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [2:0]  shadow [4];
    logic [1:0]  idx;
    logic [31:0] timer;
    logic [2:0]  cand;
    logic        cand_ok;

    // Galois right-shift; an all-zero register would lock up, so it reloads the seed
    always_comb begin
        lfsr_next = '0;
        if (lfsr == 16'h0000)
            lfsr_next = SEED;
        else if (lfsr[0])
            lfsr_next = (lfsr >> 1) ^ 16'hB400;
        else
            lfsr_next = lfsr >> 1;
    end

    always_comb begin
        cand    = lfsr[2:0];
        cand_ok = (idx == 2'd0) || (cand != shadow[idx - 2'd1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= SEED;
            shadow        <= '{default: '0};
            idx           <= '0;
            timer         <= '0;
            num_1         <= '0;
            num_2         <= '0;
            num_3         <= '0;
            num_4         <= '0;
            code_valid    <= 1'b0;
            solved        <= 1'b0;
            timeout_pulse <= 1'b0;
            checker_rst_n <= 1'b0;
            solve_count   <= '0;
        end else begin
            lfsr          <= lfsr_next;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    code_valid    <= 1'b0;
                    checker_rst_n <= 1'b1;
                    if (gen_req) begin
                        state         <= GEN;
                        idx           <= '0;
                        checker_rst_n <= 1'b0;
                    end
                end
                GEN: begin
                    code_valid    <= 1'b0;
                    checker_rst_n <= 1'b0;
                    shadow[idx]   <= cand;
                    if (cand_ok) begin
                        if (idx == 2'd3) begin
                            // last digit goes straight to num_4 so the whole code lands in one edge
                            num_1         <= shadow[0];
                            num_2         <= shadow[1];
                            num_3         <= shadow[2];
                            num_4         <= cand;
                            state         <= ARMED;
                            code_valid    <= 1'b1;
                            checker_rst_n <= 1'b1;
                            timer         <= '0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                ARMED: begin
                    if (pass_flag) begin
                        state      <= SOLVED;
                        code_valid <= 1'b0;
                        solved     <= 1'b1;
                        if (solve_count != '1)
                            solve_count <= solve_count + CNT_W'(1);
                    end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
                        state         <= GEN;
                        idx           <= '0;
                        timer         <= '0;
                        timeout_pulse <= 1'b1;
                        code_valid    <= 1'b0;
                        checker_rst_n <= 1'b0;
                    end else if (gen_req) begin
                        state         <= GEN;
                        idx           <= '0;
                        timer         <= '0;
                        code_valid    <= 1'b0;
                        checker_rst_n <= 1'b0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                SOLVED: begin
                    code_valid <= 1'b0;
                    if (gen_req) begin
                        state         <= GEN;
                        idx           <= '0;
                        solved        <= 1'b0;
                        checker_rst_n <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_gen.sv
// Directed bench for code_gen: reference LFSR plus digit-selection model,
// table of solve rounds, and hand sequences for timeout and mid-GEN reset.
module tb_code_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       gen_req;
    logic       pass_flag;
    logic [2:0] num_1, num_2, num_3, num_4;
    logic       code_valid, solved, timeout_pulse, checker_rst_n;
    logic [1:0] solve_count;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [15:0] ref_lfsr;
    logic [11:0] prev_code;

    typedef struct {
        int unsigned pass_delay;
        logic [1:0]  exp_count;
    } round_t;

    code_gen #(.SEED(SEED), .TIMEOUT_CYCLES(32'd20), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .gen_req(gen_req), .pass_flag(pass_flag),
        .num_1(num_1), .num_2(num_2), .num_3(num_3), .num_4(num_4),
        .code_valid(code_valid), .solved(solved), .timeout_pulse(timeout_pulse),
        .checker_rst_n(checker_rst_n), .solve_count(solve_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        if (v == 16'h0000) return SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) ref_lfsr <= reset ? SEED : step(ref_lfsr);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Digit selection from the spec: accept a candidate unless it repeats the previous digit
    task automatic gen_expect(input logic [15:0] start, output logic [11:0] code, output int unsigned len);
        logic [15:0] v;
        logic [2:0]  d [4];
        int unsigned n;
        v = start; n = 0; len = 0;
        d = '{default: '0};
        while (n < 4 && len < 64) begin
            if (n == 0 || v[2:0] != d[n-1]) begin
                d[n] = v[2:0];
                n++;
            end
            len++;
            v = step(v);
        end
        code = {d[0], d[1], d[2], d[3]};
    endtask

    task automatic gen_and_check(input bit drive_req);
        logic [11:0] exp_code;
        int unsigned len, low;
        bit stable;
        if (drive_req) begin
            gen_req = 1'b1;
            tick();
            gen_req = 1'b0;
        end
        gen_expect(ref_lfsr, exp_code, len);
        chk("gen_entry_valid", {31'd0, code_valid}, 32'd0);
        chk("gen_entry_solved", {31'd0, solved}, 32'd0);
        low = 0; stable = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            if (checker_rst_n === 1'b0) low++;
            if ({num_1, num_2, num_3, num_4} !== prev_code) stable = 1'b0;
            tick();
        end
        chk("gen_rst_low_cycles", low, len);
        chk("gen_rst_low_min4", {31'd0, low >= 4}, 32'd1);
        chk("gen_num_held", {31'd0, stable}, 32'd1);
        chk("armed_valid", {31'd0, code_valid}, 32'd1);
        chk("armed_rst_n", {31'd0, checker_rst_n}, 32'd1);
        chk("armed_code", {20'd0, num_1, num_2, num_3, num_4}, {20'd0, exp_code});
        chk("adjacent_distinct", {31'd0, (num_1 != num_2) && (num_2 != num_3) && (num_3 != num_4)}, 32'd1);
        prev_code = exp_code;
    endtask

    initial begin
        round_t rounds [5];
        int unsigned cnt;
        rounds[0] = '{pass_delay: 0,  exp_count: 2'd1};
        rounds[1] = '{pass_delay: 3,  exp_count: 2'd2};
        rounds[2] = '{pass_delay: 19, exp_count: 2'd3};  // pass on the expiry cycle
        rounds[3] = '{pass_delay: 5,  exp_count: 2'd3};
        rounds[4] = '{pass_delay: 1,  exp_count: 2'd3};

        reset = 1'b1; gen_req = 1'b0; pass_flag = 1'b0;
        prev_code = '0;
        repeat (3) tick();
        chk("rst_num", {20'd0, num_1, num_2, num_3, num_4}, 32'd0);
        chk("rst_flags", {28'd0, code_valid, solved, timeout_pulse, checker_rst_n}, 32'd0);
        chk("rst_count", {30'd0, solve_count}, 32'd0);
        chk("rst_lfsr", {16'd0, dut.lfsr}, {16'd0, SEED});

        reset = 1'b0;
        tick();
        chk("idle_rst_n", {31'd0, checker_rst_n}, 32'd1);
        pass_flag = 1'b1;
        tick();
        pass_flag = 1'b0;
        chk("idle_pass_ignored", {29'd0, solved, code_valid, solve_count != 2'd0}, 32'd0);
        repeat (6) tick();

        // first code, then let it expire
        gen_and_check(1'b1);
        cnt = 0;
        while (timeout_pulse !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("timeout_latency", cnt, 32'd20);
        chk("timeout_valid_drop", {30'd0, code_valid, checker_rst_n}, 32'd0);
        gen_and_check(1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        prev_code = '0;
        chk("rst2_count", {30'd0, solve_count}, 32'd0);
        tick();

        for (int r = 0; r < 5; r++) begin
            gen_and_check(1'b1);
            repeat (rounds[r].pass_delay) tick();
            pass_flag = 1'b1;
            tick();
            pass_flag = 1'b0;
            chk($sformatf("round%0d_solved", r), {30'd0, solved, code_valid}, 32'd2);
            chk($sformatf("round%0d_no_timeout", r), {31'd0, timeout_pulse}, 32'd0);
            chk($sformatf("round%0d_count", r), {30'd0, solve_count}, {30'd0, rounds[r].exp_count});
            chk($sformatf("round%0d_num_held", r), {20'd0, num_1, num_2, num_3, num_4}, {20'd0, prev_code});
        end

        // reset two cycles into GEN
        gen_req = 1'b1;
        tick();
        gen_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        prev_code = '0;
        chk("midgen_rst_num", {20'd0, num_1, num_2, num_3, num_4}, 32'd0);
        chk("midgen_rst_flags", {28'd0, code_valid, solved, timeout_pulse, checker_rst_n}, 32'd0);
        tick();
        chk("midgen_idle", {31'd0, checker_rst_n}, 32'd1);
        gen_and_check(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
